rsa_keygen_seq: RTL and testbench

Sequential, parametrised RSA key-generation engine. Accepts primes P, Q and public exponent E, then returns modulus N = P·Q and private exponent D = E⁻¹ mod φ, where φ = (P−1)(Q−1). D is computed with an iterative extended Euclidean algorithm, one quotient step per clock. The engine lifts the old fixed-depth combinational key generator to any WIDTH and adds a handshake, a busy indication and a non-invertible-E error flag. It sits in front of the modular-exponentiation datapath as the key-setup stage.

---
 rtl/rsa_keygen_seq_if.sv | 27 ++
 rtl/rsa_keygen_seq.sv | 168 ++++++++++++++++
 tb/tb_rsa_keygen_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rsa_keygen_seq_if.sv
// Request/result bundle for the RSA key-setup engine.
// The master drives P, Q and E; the slave returns N, D, busy and error status.
interface rsa_keygen_seq_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned W2 = 2 * WIDTH;

    logic             in_valid;
    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_q;
    logic [W2-1:0]    in_e;
    logic             busy;
    logic             out_valid;
    logic [W2-1:0]    out_n;
    logic [W2-1:0]    out_d;
    logic             out_err;

    modport master (
        output in_valid, in_p, in_q, in_e,
        input  busy, out_valid, out_n, out_d, out_err
    );

    modport slave (
        input  in_valid, in_p, in_q, in_e,
        output busy, out_valid, out_n, out_d, out_err
    );
endinterface

// File: rtl/rsa_keygen_seq.sv
// RSA key setup: N = P*Q and D = E^-1 mod (P-1)(Q-1).
// D comes from an extended Euclid that retires one quotient step per clock.
module rsa_keygen_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rsa_keygen_seq_if.slave  kg_if
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned TW = W2 + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        STEP = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    p_q, p_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic [W2-1:0]       e_q, e_d;
    logic [W2-1:0]       n_q, n_d;
    logic [W2-1:0]       phi_q, phi_d;
    logic [W2-1:0]       r0_q, r0_d;
    logic [W2-1:0]       r1_q, r1_d;
    logic signed [TW-1:0] t0_q, t0_d;
    logic signed [TW-1:0] t1_q, t1_d;
    logic                err_q, err_d;

    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic                out_err_q, out_err_d;
    logic [W2-1:0]       out_n_q, out_n_d;
    logic [W2-1:0]       out_d_q, out_d_d;

    logic [W2-1:0]        quot_c;
    logic [W2-1:0]        rem_c;
    logic [W2-1:0]        n_c;
    logic [W2-1:0]        phi_c;
    logic                 pq_bad_c;
    logic signed [TW-1:0] tnext_c;
    logic signed [TW-1:0] dpos_c;

    // Euclid step datapath, modulus/totient and final sign fix-up of t0.
    always_comb begin
        quot_c = '0;
        if (r1_q != '0) begin
            quot_c = r0_q / r1_q;
        end
        rem_c    = r0_q - W2'(quot_c * r1_q);
        tnext_c  = t0_q - TW'($signed({2'b00, quot_c}) * t1_q);
        n_c      = W2'(p_q) * W2'(q_q);
        phi_c    = (W2'(p_q) - W2'(1)) * (W2'(q_q) - W2'(1));
        pq_bad_c = (p_q < WIDTH'(2)) || (q_q < WIDTH'(2));
        dpos_c   = t0_q[TW-1] ? (t0_q + $signed(TW'(phi_q))) : t0_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        e_d         = e_q;
        n_d         = n_q;
        phi_d       = phi_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        out_n_d     = '0;
        out_d_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (kg_if.in_valid) begin
                    p_d     = kg_if.in_p;
                    q_d     = kg_if.in_q;
                    e_d     = kg_if.in_e;
                    state_d = INIT;
                end
            end
            INIT: begin
                n_d     = n_c;
                phi_d   = phi_c;
                r0_d    = phi_c;
                r1_d    = e_q;
                t0_d    = '0;
                t1_d    = TW'(1);
                err_d   = pq_bad_c;
                state_d = pq_bad_c ? OUT : STEP;
            end
            STEP: begin
                if (r1_q != '0) begin
                    r0_d = r1_q;
                    r1_d = rem_c;
                    t0_d = t1_q;
                    t1_d = tnext_c;
                end else begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                out_n_d     = n_q;
                // Remainder chain ends at gcd(E, phi); only gcd == 1 yields an inverse.
                if (err_q || (r0_q != W2'(1))) begin
                    out_err_d = 1'b1;
                end else begin
                    out_d_d = W2'(dpos_c);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Busy stays up through the cycle in which the result is presented.
        busy_d = (state_d != IDLE) || (state_q == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            q_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            phi_q       <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_n_q     <= '0;
            out_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            e_q         <= e_d;
            n_q         <= n_d;
            phi_q       <= phi_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_n_q     <= out_n_d;
            out_d_q     <= out_d_d;
        end
    end

    assign kg_if.busy      = busy_q;
    assign kg_if.out_valid = out_valid_q;
    assign kg_if.out_err   = out_err_q;
    assign kg_if.out_n     = out_n_q;
    assign kg_if.out_d     = out_d_q;
endmodule

// File: tb/tb_rsa_keygen_seq.sv
// Directed bench for rsa_keygen_seq: a WIDTH=4 and a WIDTH=8 instance share one clock.
// Latency is counted in rising edges after the edge that samples in_valid.
module tb_rsa_keygen_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rsa_keygen_seq_if #(.WIDTH(4)) if4 ();
    rsa_keygen_seq_if #(.WIDTH(8)) if8 ();

    rsa_keygen_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .kg_if(if4));
    rsa_keygen_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .kg_if(if8));

    typedef struct {
        bit w8;
        int p;
        int q;
        int e;
        int n;
        int d;
        bit err;
        int lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt4 = 0;

    always @(negedge clk) if (if4.out_valid === 1'b1) vcnt4++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample(input bit w8, output logic ov, output logic bz, output logic er,
                          output logic [15:0] n, output logic [15:0] d);
        if (w8) begin
            ov = if8.out_valid; bz = if8.busy; er = if8.out_err;
            n = if8.out_n; d = if8.out_d;
        end else begin
            ov = if4.out_valid; bz = if4.busy; er = if4.out_err;
            n = 16'(if4.out_n); d = 16'(if4.out_d);
        end
    endtask

    // One-cycle in_valid strobe; returns at the falling edge after the sampling edge.
    task automatic start_req(input bit w8, input int p, input int q, input int e);
        @(negedge clk);
        if (w8) begin
            if8.in_valid = 1'b1; if8.in_p = 8'(p); if8.in_q = 8'(q); if8.in_e = 16'(e);
        end else begin
            if4.in_valid = 1'b1; if4.in_p = 4'(p); if4.in_q = 4'(q); if4.in_e = 8'(e);
        end
        @(negedge clk);
        if4.in_valid = 1'b0;
        if8.in_valid = 1'b0;
    endtask

    task automatic wait_result(input bit w8, output int lat, output bit got,
                               output logic [15:0] n, output logic [15:0] d,
                               output logic er, output logic bz);
        logic ov;
        got = 1'b0; lat = 0; n = '0; d = '0; er = 1'b0; bz = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            sample(w8, ov, bz, er, n, d);
            if (ov === 1'b1) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat; bit got;
        logic [15:0] n, d; logic er, bz, ov;
        start_req(v.w8, v.p, v.q, v.e);
        sample(v.w8, ov, bz, er, n, d);
        chk({tag, " busy_after_accept"}, 32'(bz), 32'd1);
        wait_result(v.w8, lat, got, n, d, er, bz);
        chk({tag, " timeout"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " out_n"}, 32'(n), 32'(v.n));
        chk({tag, " out_d"}, 32'(d), 32'(v.d));
        chk({tag, " out_err"}, 32'(er), 32'(v.err));
        chk({tag, " busy_with_valid"}, 32'(bz), 32'd1);
        @(posedge clk);
        #1;
        sample(v.w8, ov, bz, er, n, d);
        chk({tag, " valid_one_cycle"}, 32'(ov), 32'd0);
        chk({tag, " outputs_cleared"}, {n, d}, 32'd0);
        chk({tag, " busy_released"}, 32'(bz), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int lat; bit got; int c0;
        logic [15:0] n, d; logic er, bz, ov;

        //          w8  P   Q   E    N     D     err lat
        vecs[0] = '{0,  3,  5,  3,   15,   3,    0,  6};
        vecs[1] = '{0,  7,  11, 7,   77,   43,   0,  7};
        vecs[2] = '{0,  5,  7,  6,   35,   0,    1,  4};
        vecs[3] = '{0,  1,  5,  3,   5,    0,    1,  2};
        vecs[4] = '{0,  2,  2,  5,   4,    0,    0,  5};
        vecs[5] = '{1,  61, 53, 17,  3233, 2753, 0,  7};
        vecs[6] = '{0,  3,  5,  11,  15,   3,    0,  8};
        vecs[7] = '{0,  3,  5,  0,   15,   0,    1,  3};

        if4.in_valid = 1'b0; if4.in_p = '0; if4.in_q = '0; if4.in_e = '0;
        if8.in_valid = 1'b0; if8.in_p = '0; if8.in_q = '0; if8.in_e = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sample(1'b0, ov, bz, er, n, d);
        chk("reset w4 valid/busy/err", {29'd0, ov, bz, er}, 32'd0);
        chk("reset w4 n/d", {n, d}, 32'd0);
        sample(1'b1, ov, bz, er, n, d);
        chk("reset w8 valid/busy/err", {29'd0, ov, bz, er}, 32'd0);
        chk("reset w8 n/d", {n, d}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Second request while busy must be dropped; only the first produces a result.
        c0 = vcnt4;
        start_req(1'b0, 7, 11, 7);
        if4.in_valid = 1'b1; if4.in_p = 4'd3; if4.in_q = 4'd5; if4.in_e = 8'd3;
        @(negedge clk);
        if4.in_valid = 1'b0;
        wait_result(1'b0, lat, got, n, d, er, bz);
        chk("busy_drop timeout", 32'(got), 32'd1);
        chk("busy_drop latency", 32'(lat), 32'd6);
        chk("busy_drop out_n", 32'(n), 32'd77);
        chk("busy_drop out_d", 32'(d), 32'd43);
        repeat (12) @(negedge clk);
        chk("busy_drop valid_count", 32'(vcnt4 - c0), 32'd1);

        // New request strobed in the out_valid cycle is accepted back-to-back.
        start_req(1'b0, 3, 5, 3);
        wait_result(1'b0, lat, got, n, d, er, bz);
        chk("b2b first out_d", 32'(d), 32'd3);
        start_req(1'b0, 5, 7, 6);
        wait_result(1'b0, lat, got, n, d, er, bz);
        chk("b2b second timeout", 32'(got), 32'd1);
        chk("b2b second latency", 32'(lat), 32'd4);
        chk("b2b second out_n", 32'(n), 32'd35);
        chk("b2b second out_err", 32'(er), 32'd1);
        repeat (3) @(negedge clk);

        // Reset in cycle 3 aborts the computation without a result.
        c0 = vcnt4;
        start_req(1'b0, 7, 11, 7);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sample(1'b0, ov, bz, er, n, d);
        chk("abort valid/busy/err", {29'd0, ov, bz, er}, 32'd0);
        chk("abort n/d", {n, d}, 32'd0);
        @(negedge clk);
        sample(1'b0, ov, bz, er, n, d);
        chk("abort held busy", 32'(bz), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort no out_valid", 32'(vcnt4 - c0), 32'd0);
        run_vec(vecs[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
